core_wb_bridge: RTL
===================

# core_wb_bridge

Registered bus bridge between a single-port RISC-V core memory interface and a Wishbone classic master port. It latches each core request, drives a cyc/stb cycle until the slave acks, errs or times out, then returns read data with a one-cycle ready pulse. It holds the core stalled for the whole transaction, so the core needs no handshake logic of its own. It sits directly upstream of the processor-CI controller or memory bus, in place of tying cyc/stb permanently high.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; the sel width is DATA_WIDTH/8
- TIMEOUT_CYCLES, 255, maximum number of cycles in BUS before the bridge aborts; 0 disables the timeout

Ports (one clock; reset is asynchronous and active-low):
- sys_clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- core_req_i  in  1  core requests an access; tie to 1 for cores that access every cycle
- core_we_i  in  1  1 = write, 0 = read
- core_addr_i  in  ADDR_WIDTH  address
- core_data_i  in  DATA_WIDTH  write data
- core_sel_i  in  DATA_WIDTH/8  byte enables
- core_data_o  out  DATA_WIDTH  read data; held until the next completed read
- core_ready_o  out  1  one-cycle pulse when a transaction completes
- core_err_o  out  1  one-cycle pulse, coincident with core_ready_o, on bus error or timeout
- core_stall_o  out  1  core must hold its state and request while this is high
- wb_cyc_o, wb_stb_o  out  1  Wishbone cycle and strobe; always equal
- wb_we_o  out  1  write enable
- wb_addr_o  out  ADDR_WIDTH  address
- wb_data_o  out  DATA_WIDTH  write data
- wb_sel_o  out  DATA_WIDTH/8  byte select
- wb_data_i  in  DATA_WIDTH  read data
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  bus error

## Operation
- The FSM has three states: IDLE, BUS and DONE.
- **IDLE**
  - If core_req_i=1 at a clock edge, the bridge latches we, addr, data and sel into the wb_* registers.
  - At the same edge it sets wb_cyc_o=wb_stb_o=1 and moves to BUS.
- **BUS**
  - cyc and stb stay high and the wb_* outputs stay stable.
  - The timeout counter increments every cycle.
  - On wb_err_i=1, or when the counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES≠0):
    - cyc and stb drop and the bridge moves to DONE with the error flag set.
    - For a read, core_data_o becomes all-ones.
  - Otherwise, on wb_ack_i=1:
    - cyc and stb drop and the bridge moves to DONE.
    - For a read, core_data_o ← wb_data_i. For a write, core_data_o is unchanged.
  - If err and ack are asserted in the same cycle, err wins.
- **DONE**
  - core_ready_o=1 and core_err_o=error flag, for exactly this cycle.
  - The counter and the error flag clear.
  - If core_req_i=1, the bridge latches the new request and goes straight to BUS (back-to-back). Otherwise it goes to IDLE.
- **core_stall_o** (combinational) = (state==BUS) | ((state==IDLE | state==DONE) & core_req_i).
- wb_ack_i and wb_err_i are ignored outside BUS.
- Core inputs are sampled only when a request is latched. Later changes during BUS have no effect.
- **Counter**
  - Width is $clog2(TIMEOUT_CYCLES+1), minimum 1.
  - It saturates and never wraps.
- **Reset**
  - Asynchronous assertion forces state IDLE immediately, mid-transaction included.
  - cyc, stb, we, ready, err and stall (stall ignoring core_req_i) all go to 0.
  - addr, data, sel and core_data_o go to 0, and the counter goes to 0.
  - Deassertion is synchronous to sys_clk.

## Timing
- A request sampled at edge 0 produces cyc/stb at cycle 1.
- A slave that acks in cycle 1 produces core_ready_o in cycle 2, so minimum latency is 2 cycles. Each wait state adds 1.
- Back-to-back throughput is one transaction per 2 cycles with zero-wait slaves.
- cyc/stb are registered and are never high in DONE or IDLE.
- A timeout with TIMEOUT_CYCLES=N gives cyc high for exactly N cycles, then core_ready_o and core_err_o at cycle N+1 after cyc rises.
- All outputs except core_stall_o are registered.

## Test plan
- **Zero-wait read:** req read at addr 0x100; slave acks in the first cyc cycle with data 0x12345678 → cyc high for 1 cycle, ready at cycle 2, core_data_o=0x12345678, err=0.
- **Write with 3 wait states:** req write addr 0x200, data 0xA5A5A5A5, sel 4'b0011 → wb_* stable for 4 cycles, ready once, core_data_o unchanged.
- **Timeout:** TIMEOUT_CYCLES=4, slave never acks → cyc high exactly 4 cycles, then ready=err=1, core_data_o=0xFFFFFFFF; the next zero-wait read succeeds with err=0.
- **Err/ack collision:** wb_err_i and wb_ack_i asserted in the same cycle during a read → err=1, core_data_o=0xFFFFFFFF.
- **Back-to-back:** core_req_i tied 1, zero-wait slave returning 1, 2, 3 → ready every 2nd cycle, data sequence 1, 2, 3, no idle cycle between transactions; a spurious ack in DONE is ignored.
- **Reset mid-transaction:** assert rst_n=0 while in BUS → cyc, stb, stall and ready go to 0 before the next edge; after release, a new read completes normally.

Source files
------------

// File: rtl/core_wb_bridge.sv
// core_wb_bridge
//
// Registered bridge from a single-port RISC-V core memory interface to a
// Wishbone classic master port. Each core request is captured into the wb_*
// registers, a cyc/stb cycle is held until the slave acks, errs or the
// timeout expires, and completion is reported with a one-cycle ready pulse.
//
// Core-side handshake (req / stall / ready):
//   The core raises core_req_i with we/addr/data/sel valid and must hold all
//   of them while core_stall_o is high. The request is consumed at the first
//   clock edge where the bridge is in IDLE or DONE. Completion is a single
//   cycle with core_ready_o=1, with core_err_o qualifying it in the same
//   cycle. A request still asserted during that completion cycle is taken
//   immediately, which gives back-to-back transfers.
//
// Ports:
//   sys_clk, rst_n            clock, asynchronous active-low reset
//   core_req_i .. core_sel_i  core request (sampled only when latched)
//   core_data_o               read data, held until the next completed read
//   core_ready_o, core_err_o  completion pulse and its error qualifier
//   core_stall_o              combinational stall back to the core
//   wb_*_o / wb_*_i           Wishbone classic master port
//   dbg_state                 current FSM state (IDLE=0, BUS=1, DONE=2)

module core_wb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    core_req_i,
  input  logic                    core_we_i,
  input  logic [ADDR_WIDTH-1:0]   core_addr_i,
  input  logic [DATA_WIDTH-1:0]   core_data_i,
  input  logic [DATA_WIDTH/8-1:0] core_sel_i,
  output logic [DATA_WIDTH-1:0]   core_data_o,
  output logic                    core_ready_o,
  output logic                    core_err_o,
  output logic                    core_stall_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_addr_o,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb_data_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  output logic [1:0]              dbg_state
);

  // A counter of this width can hold TIMEOUT_CYCLES itself; with the timeout
  // disabled a single saturating bit is kept so the logic stays uniform.
  localparam int CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The counter holds (cycles already spent in BUS), so the last permitted
  // BUS cycle is the one where it reads TIMEOUT_CYCLES-1.
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             latch_req;
  logic             bus_fail;
  logic             bus_ok;
  logic             bus_end;
  logic             timeout_hit;
  logic [CNT_W-1:0] cnt_q;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST));
  assign bus_end     = bus_fail | bus_ok;

  // Next-state logic. Error and timeout take priority over ack.
  always_comb begin
    state_d   = state_q;
    latch_req = 1'b0;
    bus_fail  = 1'b0;
    bus_ok    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (core_req_i) begin
          latch_req = 1'b1;
          state_d   = S_BUS;
        end
      end
      S_BUS: begin
        if (wb_err_i || timeout_hit) begin
          bus_fail = 1'b1;
          state_d  = S_DONE;
        end else if (wb_ack_i) begin
          bus_ok  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (core_req_i) begin
          latch_req = 1'b1;
          state_d   = S_BUS;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_cyc_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_addr_o    <= '0;
      wb_data_o    <= '0;
      wb_sel_o     <= '0;
      core_data_o  <= '0;
      core_ready_o <= 1'b0;
      core_err_o   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      // Both pulses are set on the edge that enters DONE and therefore last
      // exactly the one DONE cycle.
      core_ready_o <= bus_end;
      core_err_o   <= bus_fail;

      if (latch_req) begin
        wb_we_o   <= core_we_i;
        wb_addr_o <= core_addr_i;
        wb_data_o <= core_data_i;
        wb_sel_o  <= core_sel_i;
        wb_cyc_o  <= 1'b1;
      end else if (bus_end) begin
        wb_cyc_o <= 1'b0;
      end

      // Count only while the transfer is still running; saturate at all-ones.
      if (state_q == S_BUS && !bus_end) begin
        if (cnt_q != '1) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end

      if (bus_fail && !wb_we_o) begin
        core_data_o <= '1;
      end else if (bus_ok && !wb_we_o) begin
        core_data_o <= wb_data_i;
      end
    end
  end

  assign wb_stb_o = wb_cyc_o;

  // During reset the stall is forced low regardless of the request.
  assign core_stall_o = rst_n & ((state_q == S_BUS) | core_req_i);

  assign dbg_state = state_q;

endmodule
